tensor_param_stream_source: RTL and testbench



---
 rtl/tensor_stream_pkg.sv | 27 ++
 rtl/tensor_param_rom.sv | 27 ++
 rtl/tensor_param_stream_source.sv | 182 ++++++++++++++++++
 tb/tb_tensor_param_stream_source.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tensor_stream_pkg.sv
// Shared types and size helpers for the tensor parameter streamer and its ROM.
package tensor_stream_pkg;

  // Read latency of tensor_param_rom; its two output register stages are fixed.
  localparam int ROM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic int calc_depth(input int size_0, input int size_1,
                                    input int par_0, input int par_1);
    return (size_0 / par_0) * (size_1 / par_1);
  endfunction

  function automatic int calc_word_w(input int precision, input int par_0, input int par_1);
    return precision * par_0 * par_1;
  endfunction

  // Index width that stays legal (>= 1 bit) even for single-entry structures.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tensor_param_rom.sv
// Synchronous parameter ROM with two registered output stages (read latency 2).
module tensor_param_rom
  import tensor_stream_pkg::*;
#(
  parameter int    DEPTH     = 16,
  parameter int    WORD_W    = 128,
  parameter string INIT_FILE = "",
  localparam int   ADDR_W    = width_of(DEPTH)
) (
  input  logic              clk,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] stage;

  // NOTE: memory contents and data stages carry no reset; validity travels in the caller's pipeline.
  always_ff @(posedge clk) begin
    if (ce) begin
      stage <= mem[addr];
      data  <= stage;
    end
  end

endmodule

// File: rtl/tensor_param_stream_source.sv
// Streams a ROM-held 2-D parameter tensor as tiles over valid/ready, hiding ROM
// latency behind a credit-controlled prefetch FIFO; one-shot or continuous.
module tensor_param_stream_source
  import tensor_stream_pkg::*;
#(
  parameter int    TENSOR_SIZE_DIM_0 = 32,
  parameter int    TENSOR_SIZE_DIM_1 = 4,
  parameter int    PARALLELISM_DIM_0 = 4,
  parameter int    PARALLELISM_DIM_1 = 2,
  parameter int    PRECISION_0       = 16,
  parameter int    PRECISION_1       = 3,
  parameter int    REPEAT            = 2,
  parameter bit    CONTINUOUS        = 1'b0,
  parameter int    FIFO_DEPTH        = 4,
  parameter string INIT_FILE         = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [PRECISION_0-1:0] data_out [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   data_out_last
);

  localparam int LANES  = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int DEPTH  = calc_depth(TENSOR_SIZE_DIM_0, TENSOR_SIZE_DIM_1,
                                     PARALLELISM_DIM_0, PARALLELISM_DIM_1);
  localparam int WORD_W = calc_word_w(PRECISION_0, PARALLELISM_DIM_0, PARALLELISM_DIM_1);
  localparam int ADDR_W = width_of(DEPTH);
  localparam int PASS_W = width_of(REPEAT);
  localparam int PTR_W  = width_of(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W  = CNT_W + 1;

  localparam state_t RESET_STATE = CONTINUOUS ? RUN : IDLE;

  localparam bit CFG_OK = (TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0 == 0) &&
                          (TENSOR_SIZE_DIM_1 % PARALLELISM_DIM_1 == 0) &&
                          (REPEAT >= 1) && (FIFO_DEPTH >= ROM_LATENCY + 1) &&
                          (PRECISION_1 <= PRECISION_0);
  if (!CFG_OK) begin : g_cfg_error
    $error("tensor_param_stream_source: illegal parameter combination");
  end

  state_t state, state_next;

  logic [ADDR_W-1:0]      addr;
  logic [PASS_W-1:0]      pass;
  logic                   addr_last;
  logic                   issue;
  logic [ROM_LATENCY-1:0] rd_valid;
  logic [ROM_LATENCY-1:0] rd_last;
  logic [CRD_W-1:0]       inflight;
  logic [CRD_W-1:0]       credit_used;
  logic [WORD_W-1:0]      rom_data;

  logic [WORD_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  tensor_param_rom #(
    .DEPTH     (DEPTH),
    .WORD_W    (WORD_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk  (clk),
    .ce   (1'b1),
    .addr (addr),
    .data (rom_data)
  );

  // Credits cover both stored tiles and reads still in the ROM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight = inflight + CRD_W'(rd_valid[i]);
  end

  assign credit_used = CRD_W'(fifo_count) + inflight;
  assign issue       = (state == RUN) && (credit_used < CRD_W'(FIFO_DEPTH));
  assign addr_last   = (addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      pass <= '0;
    end else if (state == IDLE) begin
      addr <= '0;
      pass <= '0;
    end else if (issue) begin
      if (addr_last) begin
        addr <= '0;
        pass <= pass + 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= '0;
      rd_last  <= '0;
    end else begin
      rd_valid <= {rd_valid[ROM_LATENCY-2:0], issue};
      rd_last  <= {rd_last[ROM_LATENCY-2:0], issue && addr_last};
    end
  end

  assign push           = rd_valid[ROM_LATENCY-1];
  assign data_out_valid = (fifo_count != '0);
  assign pop            = data_out_valid && data_out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rom_data;
      fifo_last[wr_ptr] <= rd_last[ROM_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      data_out[j] = fifo_data[rd_ptr][PRECISION_0*j +: PRECISION_0];
    end
  end

  assign data_out_last = data_out_valid && fifo_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (!CONTINUOUS && issue && addr_last && (pass == PASS_W'(REPEAT - 1)))
          state_next = DRAIN;
      end
      DRAIN: begin
        if ((fifo_count == '0) && (inflight == '0)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tensor_param_stream_source.sv
// Directed bench: one-shot streamer at default sizes plus a continuous single-tile instance.
module tb_tensor_param_stream_source;

  localparam int LANES = 8;
  localparam logic [63:0] ALL_READY = '1;
  localparam logic [63:0] SPARSE_READY = 64'h6DB6_DB6D_B6DB_6DB6;

  logic clk = 1'b0;
  logic rst_n, start, ready;
  logic busy, done, valid, last;
  logic [15:0] data [LANES];
  logic start_c, ready_c;
  logic busy_c, done_c, valid_c, last_c;
  logic [15:0] data_c [LANES];
  logic [127:0] word, word_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tensor_param_stream_source #(
    .TENSOR_SIZE_DIM_0 (32),
    .TENSOR_SIZE_DIM_1 (4),
    .PARALLELISM_DIM_0 (4),
    .PARALLELISM_DIM_1 (2),
    .PRECISION_0       (16),
    .PRECISION_1       (3),
    .REPEAT            (2),
    .CONTINUOUS        (1'b0),
    .FIFO_DEPTH        (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .data_out       (data),
    .data_out_valid (valid),
    .data_out_ready (ready),
    .data_out_last  (last)
  );

  tensor_param_stream_source #(
    .TENSOR_SIZE_DIM_0 (4),
    .TENSOR_SIZE_DIM_1 (2),
    .PARALLELISM_DIM_0 (4),
    .PARALLELISM_DIM_1 (2),
    .PRECISION_0       (16),
    .PRECISION_1       (3),
    .REPEAT            (1),
    .CONTINUOUS        (1'b1),
    .FIFO_DEPTH        (4)
  ) dut_c (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start_c),
    .busy           (busy_c),
    .done           (done_c),
    .data_out       (data_c),
    .data_out_valid (valid_c),
    .data_out_ready (ready_c),
    .data_out_last  (last_c)
  );

  always_comb begin
    word   = '0;
    word_c = '0;
    for (int j = 0; j < LANES; j++) begin
      word[16*j +: 16]   = data[j];
      word_c[16*j +: 16] = data_c[j];
    end
  end

  // Word a holds element values a*8+j.
  function automatic logic [127:0] exp_word(input int a);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < LANES; j++) w[16*j +: 16] = 16'(a * 8 + j);
    return w;
  endfunction

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One start-to-done run; stall pattern pat after hold_low cycles of ready=0.
  task automatic run_stream(input string name, input logic [63:0] pat, input int hold_low,
                            input bit poke_start, input int abort_at);
    int k, beats, first_k, first_xfer_k, last_k;
    bit stalled, seen_done;
    logic [127:0] held_word;
    logic held_last;

    ready = (hold_low > 0) ? 1'b0 : pat[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_rise"}, busy, 1);
    k = 0; beats = 0; first_k = -1; first_xfer_k = -1; last_k = -1;
    stalled = 0; seen_done = 0; held_word = '0; held_last = 0;

    while (k < 300) begin
      start = 1'b0;
      if (stalled) begin
        check({name, "_stall_valid"}, valid, 1);
        check({name, "_stall_data"}, word, held_word);
        check({name, "_stall_last"}, last, held_last);
      end
      check({name, "_fifo_bound"}, dut.fifo_count <= 4, 1);
      if (first_k < 0 && valid) begin
        first_k = k;
        check({name, "_first_valid_latency"}, k, 3);
      end
      if (done) begin
        seen_done = 1;
        check({name, "_done_beats"}, beats, 32);
        check({name, "_done_after_last"}, k - last_k, 1);
        check({name, "_done_busy"}, busy, 1);
        check({name, "_done_valid"}, valid, 0);
        if (poke_start) start = 1'b1;
        break;
      end
      ready = (k < hold_low) ? 1'b0 : pat[k % 64];
      if (hold_low > 0 && k == hold_low - 1) begin
        check({name, "_hold_fifo_count"}, dut.fifo_count, 4);
        check({name, "_hold_head"}, word, exp_word(0));
      end
      if (valid && ready) begin
        check({name, "_beat_data"}, word, exp_word(beats % 16));
        check({name, "_beat_last"}, last, (beats % 16) == 15);
        if (first_xfer_k < 0) first_xfer_k = k;
        last_k = k;
        if (beats == abort_at) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          check({name, "_abort_valid"}, valid, 0);
          check({name, "_abort_busy"}, busy, 0);
          check({name, "_abort_done"}, done, 0);
          repeat (4) begin
            @(negedge clk);
            check({name, "_abort_no_done"}, done, 0);
            check({name, "_abort_idle"}, valid, 0);
          end
          return;
        end
        if (poke_start && beats == 10) start = 1'b1;
        beats++;
      end
      stalled   = valid && !ready;
      held_word = word;
      held_last = last;
      @(negedge clk);
      k++;
    end

    check({name, "_done_seen"}, seen_done, 1);
    if (pat == ALL_READY) check({name, "_no_bubble"}, last_k - first_xfer_k, 31);
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_pulse_end"}, done, 0);
    check({name, "_busy_fall"}, busy, 0);
    repeat (2) begin
      @(negedge clk);
      check({name, "_stay_idle_busy"}, busy, 0);
      check({name, "_stay_idle_valid"}, valid, 0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    ready   = 1'b1;
    start_c = 1'b0;
    ready_c = 1'b1;
    for (int a = 0; a < 16; a++) dut.u_rom.mem[a] = exp_word(a);
    dut_c.u_rom.mem[0] = exp_word(0);

    repeat (3) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_last", last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cont_valid", valid_c, 0);

    // Continuous single-tile instance: valid from cycle 3, last always set.
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("cont_valid", valid_c, k >= 3);
      if (k >= 3) begin
        check("cont_last", last_c, 1);
        check("cont_data", word_c, exp_word(0));
      end
      check("cont_done", done_c, 0);
      check("cont_busy", busy_c, 1);
      check("oneshot_idle_busy", busy, 0);
      check("oneshot_idle_valid", valid, 0);
    end

    run_stream("full_rate", ALL_READY, 0, 1'b1, -1);
    run_stream("stalls", SPARSE_READY, 0, 1'b0, -1);
    run_stream("hold_low", ALL_READY, 20, 1'b0, -1);
    run_stream("abort", ALL_READY, 0, 1'b0, 10);
    run_stream("restart", ALL_READY, 0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
